// File: rtl/novacore_pio_pkg.sv
// rtl/novacore_pio_pkg.sv - shared register map and edge-type encodings for the input PIO
package novacore_pio_pkg;
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/novacore_sync_ff.sv
// rtl/novacore_sync_ff.sv - multi-stage input synchronizer with async active-low reset
module novacore_sync_ff #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];
endmodule

// File: rtl/novacore_pio_in_edgecap.sv
// rtl/novacore_pio_in_edgecap.sv - Avalon-MM input PIO with sticky edge capture and masked irq
import novacore_pio_pkg::*;

module novacore_pio_in_edgecap #(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] edge_det;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en, rd_en;
    logic             unused_wdata;

    novacore_sync_ff #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync)
    );

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        prev_d = sync;

        if (EDGE_TYPE == EDGE_RISING) begin
            edge_det = sync & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            edge_det = ~sync & prev_q;
        end else begin
            edge_det = sync ^ prev_q;
        end

        mask_d = mask_q;
        if (wr_en && address == ADDR_IRQ_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end

        // Clear first, then OR in new edges so a colliding set wins.
        cap_d = cap_q;
        if (wr_en && address == ADDR_EDGE_CAP) begin
            cap_d = cap_q & ~writedata[WIDTH-1:0];
        end
        cap_d = cap_d | edge_det;

        readdata_d = '0;
        if (rd_en) begin
            case (address)
                ADDR_DATA:     readdata_d = 32'(sync);
                ADDR_IRQ_MASK: readdata_d = 32'(mask_q);
                ADDR_EDGE_CAP: readdata_d = 32'(cap_q);
                default:       readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= prev_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);
endmodule

// File: tb/tb_novacore_pio_in_edgecap.sv
// tb/tb_novacore_pio_in_edgecap.sv - randomized self-checking bench with history-queue reference model
module tb_novacore_pio_in_edgecap;
    localparam int W  = 8;
    localparam int ET = 0;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  samp[$];
    logic [W-1:0]  m_mask;
    logic [W-1:0]  m_cap;
    logic [31:0]   m_rd;
    logic          m_irq;

    novacore_pio_in_edgecap #(
        .WIDTH       (W),
        .EDGE_TYPE   (ET),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        samp.delete();
        repeat (SS + 1) samp.push_back('0);
        m_mask = '0;
        m_cap  = '0;
        m_rd   = '0;
        m_irq  = 1'b0;
    endtask

    // One bus cycle: drive, let the edge happen, advance the model, compare.
    task automatic cycle(input logic [1:0] a, input logic cs, input logic wn,
                         input logic [31:0] wd, input logic [W-1:0] inp);
        logic [W-1:0] s_now, s_old, edges;
        address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = inp;
        @(posedge clk);
        s_now = samp[samp.size() - SS];
        s_old = samp[samp.size() - SS - 1];
        if (ET == 0)      edges = s_now & ~s_old;
        else if (ET == 1) edges = ~s_now & s_old;
        else              edges = s_now ^ s_old;
        m_rd = '0;
        if (cs && wn) begin
            if (a == 2'd0)      m_rd = {24'd0, s_now};
            else if (a == 2'd2) m_rd = {24'd0, m_mask};
            else if (a == 2'd3) m_rd = {24'd0, m_cap};
        end
        if (cs && !wn && a == 2'd2) m_mask = wd[W-1:0];
        if (cs && !wn && a == 2'd3) m_cap = m_cap & ~wd[W-1:0];
        m_cap = m_cap | edges;
        samp.push_back(inp);
        if (samp.size() > 16) void'(samp.pop_front());
        m_irq = |(m_cap & m_mask);
        @(negedge clk);
        checks++;
        if (readdata !== m_rd) begin
            failures++;
            $display("FAIL cycle_readdata actual=%h required=%h", readdata, m_rd);
        end
        checks++;
        if (irq !== m_irq) begin
            failures++;
            $display("FAIL cycle_irq actual=%b required=%b", irq, m_irq);
        end
    endtask

    task automatic idle(input int n, input logic [W-1:0] inp);
        for (int i = 0; i < n; i++) cycle(2'd0, 1'b0, 1'b1, 32'd0, inp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd, input logic [W-1:0] inp);
        cycle(a, 1'b1, 1'b0, wd, inp);
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] inp);
        cycle(a, 1'b1, 1'b1, 32'd0, inp);
    endtask

    task automatic rand_cycle(inout logic [W-1:0] inp);
        if ($urandom_range(3) == 0) inp = W'($urandom);
        cycle(2'($urandom), 1'($urandom), 1'($urandom), $urandom, inp);
    endtask

    task automatic clean_state();
        idle(4, '0);
        wr(2'd3, 32'hFFFF_FFFF, '0);
        wr(2'd2, 32'd0, '0);
    endtask

    task automatic test_reset();
        logic [W-1:0] inp = '0;
        for (int i = 0; i < 30; i++) rand_cycle(inp);
        wr(2'd2, 32'hFF, 8'hFF);
        idle(4, 8'hFF);
        rd(2'd2, 8'hFF);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_readdata actual=%h required=%h", readdata, 32'd0);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq actual=%b required=0", irq);
        end
        address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        rd(2'd2, '0);
        rd(2'd3, '0);
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_cap_read actual=%h required=%h", readdata, 32'd0);
        end
    endtask

    task automatic test_data_read();
        idle(1, 8'hA5);
        idle(2, 8'hA5);
        rd(2'd0, 8'hA5);
        checks++;
        if (readdata !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL data_read actual=%h required=%h", readdata, 32'h0000_00A5);
        end
        idle(1, 8'hA5);
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL data_read_idle actual=%h required=%h", readdata, 32'd0);
        end
    endtask

    task automatic test_rising_capture();
        int seen = 0;
        clean_state();
        wr(2'd2, 32'h01, '0);
        for (int i = 1; i <= 5; i++) begin
            idle(1, 8'h01);
            if (irq === 1'b1 && seen == 0) seen = i;
        end
        checks++;
        if (seen != 3) begin
            failures++;
            $display("FAIL rise_latency actual=%0d required=%0d", seen, 3);
        end
        rd(2'd3, 8'h01);
        checks++;
        if (readdata !== 32'h01) begin
            failures++;
            $display("FAIL rise_cap actual=%h required=%h", readdata, 32'h01);
        end
        idle(5, 8'h00);
        rd(2'd3, 8'h00);
        checks++;
        if (readdata !== 32'h01) begin
            failures++;
            $display("FAIL fall_no_change actual=%h required=%h", readdata, 32'h01);
        end
    endtask

    task automatic test_w1c_collision();
        clean_state();
        idle(4, 8'h03);
        rd(2'd3, 8'h03);
        checks++;
        if (readdata !== 32'h03) begin
            failures++;
            $display("FAIL collide_setup actual=%h required=%h", readdata, 32'h03);
        end
        idle(4, 8'h01);
        idle(2, 8'h03);
        wr(2'd3, 32'h03, 8'h03);
        rd(2'd3, 8'h03);
        checks++;
        if (readdata !== 32'h02) begin
            failures++;
            $display("FAIL collide_w1c actual=%h required=%h", readdata, 32'h02);
        end
    endtask

    task automatic test_masking();
        clean_state();
        idle(5, 8'h04);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL mask_zero_irq actual=%b required=0", irq);
        end
        wr(2'd2, 32'h04, 8'h04);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL mask_set_irq actual=%b required=1", irq);
        end
        wr(2'd2, 32'h00, 8'h04);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL mask_clr_irq actual=%b required=0", irq);
        end
    endtask

    task automatic test_reserved();
        wr(2'd0, 32'hFFFF_FFFF, 8'h04);
        wr(2'd1, 32'hFFFF_FFFF, 8'h04);
        rd(2'd1, 8'h04);
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL rsvd_read actual=%h required=%h", readdata, 32'd0);
        end
        rd(2'd2, 8'h04);
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL rsvd_mask actual=%h required=%h", readdata, 32'd0);
        end
        rd(2'd3, 8'h04);
        checks++;
        if (readdata !== 32'h04) begin
            failures++;
            $display("FAIL rsvd_cap actual=%h required=%h", readdata, 32'h04);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] inp = 8'h04;
        for (int i = 0; i < 400; i++) rand_cycle(inp);
    endtask

    initial begin
        reset_n = 1'b0;
        address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        test_reset();
        test_data_read();
        test_rising_capture();
        test_w1c_collision();
        test_masking();
        test_reserved();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
